// File: rtl/debug_dump_pkg.sv
// Shared types and frame/controller constants for the debug dump sequencer.
// Optional build macro DEBUG_DUMP_TIMESTAMP_EN is consumed by the top only.
package debug_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FREEZE,
        ST_REQ,
        ST_WAIT,
        ST_OUT,
        ST_DONE
    } dd_state_e;

    localparam int ID_MSB   = 31;
    localparam int ID_LSB   = 26;
    localparam int RD_BIT   = 25;
    localparam int WIDX_LSB = 0;
    localparam int WIDX_W   = 4;

    localparam logic [5:0] CID_24   = 6'b1001_00;
    localparam logic [5:0] CID_25   = 6'b1001_01;
    localparam logic [5:0] CID_26   = 6'b1001_10;
    localparam logic [5:0] CID_27   = 6'b1001_11;
    localparam logic [5:0] CID_28   = 6'b1010_00;
    localparam logic [5:0] CID_29   = 6'b1010_01;
    localparam logic [5:0] CID_2A   = 6'b1010_10;
    localparam logic [5:0] CID_2B   = 6'b1010_11;
    localparam logic [5:0] CID_20   = 6'b1000_00;
    localparam logic [5:0] CID_21   = 6'b1000_01;
    localparam logic [5:0] CID_NONE = 6'b0000_00;

    function automatic logic [31:0] req_frame(
        input logic [5:0] id,
        input logic [3:0] widx
    );
        logic [31:0] f;
        f = '0;
        f[ID_MSB:ID_LSB] = id;
        f[RD_BIT] = 1'b1;
        f[WIDX_LSB +: WIDX_W] = widx;
        return f;
    endfunction

endpackage

// File: rtl/debug_dump_sequencer_if.sv
// Pipeline frame port, control and captured-word stream of the dump sequencer.
// master = sequencer side, slave = pipeline/host side.
interface debug_dump_sequencer_if #(
    parameter int NB_FRAME = 32
);
    logic                i_start;
    logic                i_abort;
    logic                o_pipe_valid;
    logic [NB_FRAME-1:0] o_frame_to_pipe;
    logic [NB_FRAME-1:0] i_frame_from_pipe;
    logic [NB_FRAME-1:0] o_data;
    logic [3:0]          o_ch_idx;
    logic [3:0]          o_word_idx;
    logic                o_valid;
    logic                i_ready;
    logic                o_last;
    logic                o_busy;
    logic                o_done;

    modport master (
        input  i_start, i_abort, i_frame_from_pipe, i_ready,
        output o_pipe_valid, o_frame_to_pipe, o_data, o_ch_idx,
        output o_word_idx, o_valid, o_last, o_busy, o_done
    );

    modport slave (
        output i_start, i_abort, i_frame_from_pipe, i_ready,
        input  o_pipe_valid, o_frame_to_pipe, o_data, o_ch_idx,
        input  o_word_idx, o_valid, o_last, o_busy, o_done
    );
endinterface

// File: rtl/debug_dump_walker.sv
// Channel/word counters and per-channel ID and word-count lookup.
module debug_dump_walker #(
    parameter int                     N_CH     = 3,
    parameter int                     NB_ID    = 6,
    parameter logic [N_CH*NB_ID-1:0] CH_IDS   = {6'b1010_00, 6'b1001_10, 6'b1001_00},
    parameter logic [N_CH*4-1:0]     CH_WORDS = {4'd2, 4'd3, 4'd1}
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_step,
    output logic [3:0]       o_ch,
    output logic [3:0]       o_word,
    output logic [NB_ID-1:0] o_id,
    output logic             o_run_end
);
    logic [3:0] ch_q;
    logic [3:0] w_q;
    logic [3:0] w_lim;
    logic       ch_end;

    assign o_id      = CH_IDS[int'(ch_q)*NB_ID +: NB_ID];
    assign w_lim     = CH_WORDS[int'(ch_q)*4 +: 4] - 4'd1;
    assign ch_end    = (w_q == w_lim);
    assign o_run_end = ch_end && (ch_q == 4'(N_CH-1));
    assign o_ch      = ch_q;
    assign o_word    = w_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_chk
        if (CH_WORDS[i*4 +: 4] == 4'd0) begin : g_bad
            $error("CH_WORDS entry %0d is zero", i);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ch_q <= '0;
            w_q  <= '0;
        end else if (i_clr) begin
            ch_q <= '0;
            w_q  <= '0;
        end else if (i_step && !o_run_end) begin
            if (ch_end) begin
                w_q  <= '0;
                ch_q <= ch_q + 4'd1;
            end else begin
                w_q <= w_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Debug master: freezes the pipeline and streams every controller latch word.
// DEBUG_DUMP_TIMESTAMP_EN adds a cycle-count header word to each run.
module debug_dump_sequencer
    import debug_dump_pkg::*;
#(
    parameter int                     NB_FRAME     = 32,
    parameter int                     N_CH         = 3,
    parameter int                     NB_ID        = 6,
    parameter logic [N_CH*NB_ID-1:0] CH_IDS       = {6'b1010_00, 6'b1001_10, 6'b1001_00},
    parameter logic [N_CH*4-1:0]     CH_WORDS     = {4'd2, 4'd3, 4'd1},
    parameter int                     RESP_LATENCY = 2
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    debug_dump_sequencer_if.master bus
);
    localparam logic [3:0] WAIT_INIT = 4'(RESP_LATENCY - 1);

    if (RESP_LATENCY < 1) begin : g_bad_lat
        $error("RESP_LATENCY must be at least 1");
    end

    dd_state_e           state_q, state_d;
    logic [3:0]          wait_q;
    logic                abort_q;
    logic                hdr_q;
    logic [NB_FRAME-1:0] data_q;
    logic [NB_FRAME-1:0] snap;
    logic                step;
    logic [3:0]          ch, w;
    logic [NB_ID-1:0]    id;
    logic                run_end;

`ifdef DEBUG_DUMP_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
    logic [31:0] ts_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) ts_q <= '0;
        else          ts_q <= ts_q + 32'd1;
    end

    assign snap = NB_FRAME'(ts_q);
`else
    localparam bit TS_EN = 1'b0;
    assign snap = '0;
`endif

    debug_dump_walker #(
        .N_CH     (N_CH),
        .NB_ID    (NB_ID),
        .CH_IDS   (CH_IDS),
        .CH_WORDS (CH_WORDS)
    ) u_walker (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clr     (state_q == ST_FREEZE),
        .i_step    (step),
        .o_ch      (ch),
        .o_word    (w),
        .o_id      (id),
        .o_run_end (run_end)
    );

    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (bus.i_start) state_d = ST_FREEZE;
            ST_FREEZE: state_d = TS_EN ? ST_OUT : ST_REQ;
            ST_REQ:    state_d = bus.i_abort ? ST_DONE : ST_WAIT;
            ST_WAIT:   if (wait_q == 4'd0) state_d = ST_OUT;
            ST_OUT: begin
                if (bus.i_abort) begin
                    state_d = ST_DONE;
                end else if (bus.i_ready) begin
                    if (hdr_q) begin
                        state_d = ST_REQ;
                    end else if (abort_q || run_end) begin
                        state_d = ST_DONE;
                    end else begin
                        step    = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            abort_q <= 1'b0;
            hdr_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: abort_q <= 1'b0;
                ST_FREEZE: begin
                    abort_q <= 1'b0;
                    hdr_q   <= TS_EN;
                    if (TS_EN) data_q <= snap;
                end
                ST_REQ: wait_q <= WAIT_INIT;
                ST_WAIT: begin
                    // an abort here must not drop the word already in flight
                    if (bus.i_abort) abort_q <= 1'b1;
                    if (wait_q == 4'd0) data_q <= bus.i_frame_from_pipe;
                    else                wait_q <= wait_q - 4'd1;
                end
                ST_OUT:  if (bus.i_ready && !bus.i_abort) hdr_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.o_pipe_valid    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign bus.o_frame_to_pipe = ((state_q == ST_REQ) || (state_q == ST_WAIT))
                               ? NB_FRAME'(req_frame(6'(id), w)) : '0;
    assign bus.o_data          = data_q;
    assign bus.o_ch_idx        = hdr_q ? 4'hF : ch;
    assign bus.o_word_idx      = hdr_q ? 4'h0 : w;
    assign bus.o_valid         = (state_q == ST_OUT);
    assign bus.o_last          = (state_q == ST_OUT) && run_end && !hdr_q && !abort_q;
    assign bus.o_busy          = (state_q != ST_IDLE);
    assign bus.o_done          = (state_q == ST_DONE);

endmodule
